unibus_ram_slave: RTL and testbench

- Unibus memory slave that serves DATI/DATIP/DATO/DATOB cycles from an FPGA block-RAM port.
- Sits on the wire-ANDed unibus alongside the simulated 11/34 CPU, the M9312 ROM and the Zynq bus interface.
- Consumes MSYN/A/C/D from the bus and produces active-high D and SSYN, which the board ANDs into the bus.
- Handles master deskew and the full interlocked MSYN/SSYN handshake.

---
 rtl/unibus_ram_slave.sv | 117 +++++++++++
 tb/tb_unibus_ram_slave.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/unibus_ram_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// unibus_ram_slave : Unibus DATI/DATIP/DATO/DATOB memory slave on a block-RAM port
// rev 1.0
// ---------------------------------------------------------------------------
module unibus_ram_slave #(
   parameter logic [17:0] BASE   = 18'o000000,
   parameter int          SIZE   = 28672,
   parameter int          AW     = 15,
   parameter int          DESKEW = 15
) (
   input  logic          CLOCK,
   input  logic          RESET_N,
   input  logic [17:0]   a_in_h,
   input  logic [1:0]    c_in_h,
   input  logic [15:0]   d_in_h,
   input  logic          msyn_in_h,
   input  logic          init_in_h,
   output logic [15:0]   d_out_h,
   output logic          ssyn_out_h,
   output logic [AW-1:0] mem_addr,
   output logic [15:0]   mem_wdata,
   input  logic [15:0]   mem_rdata,
   output logic          mem_enab,
   output logic [1:0]    mem_wena,
   output logic          busy_h
);

   localparam int          CW = $clog2(DESKEW + 1);
   localparam logic [18:0] LO = {1'b0, BASE};
   localparam logic [18:0] HI = LO + 19'(2 * SIZE);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DESKEW = 3'd1,
      S_RDREQ  = 3'd2,
      S_RDCAP  = 3'd3,
      S_WRREQ  = 3'd4,
      S_SSYN   = 3'd5,
      S_WAITLO = 3'd6
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic [1:0]    wena_q;
   logic [18:0]   a_ext, off;
   logic          hit, sample;

   // 19-bit compare so the window can never wrap past the top of the address space
   always_comb begin
      a_ext  = {1'b0, a_in_h};
      off    = a_ext - LO;
      hit    = (a_ext >= LO) && (a_ext < HI);
      sample = (state == S_DESKEW) && msyn_in_h && (cnt == '0);
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (msyn_in_h) state_nx = S_DESKEW;
         S_DESKEW: begin
            if (!msyn_in_h)
               state_nx = S_IDLE;
            else if (cnt == '0)
               state_nx = !hit ? S_WAITLO : (c_in_h[1] ? S_WRREQ : S_RDREQ);
         end
         S_RDREQ:  state_nx = S_RDCAP;
         S_RDCAP:  state_nx = S_SSYN;
         S_WRREQ:  state_nx = S_SSYN;
         S_SSYN,
         S_WAITLO: if (!msyn_in_h) state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
      if (init_in_h) state_nx = S_WAITLO;
   end

   assign mem_enab = (state == S_RDREQ) || (state == S_WRREQ);
   assign mem_wena = (state == S_WRREQ) ? wena_q : 2'b00;
   assign busy_h   = (state != S_IDLE);

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state      <= S_IDLE;
         cnt        <= '0;
         wena_q     <= 2'b00;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         d_out_h    <= '0;
         ssyn_out_h <= 1'b0;
      end else begin
         state <= state_nx;

         if (state == S_IDLE)
            cnt <= CW'(DESKEW - 1);
         else if (state == S_DESKEW && cnt != '0)
            cnt <= cnt - CW'(1);

         if (sample && hit) begin
            mem_addr <= AW'(off >> 1);
            if (c_in_h[1]) begin
               mem_wdata <= d_in_h;
               wena_q    <= !c_in_h[0] ? 2'b11 : (a_in_h[0] ? 2'b10 : 2'b01);
            end
         end

         // SSYN lags the data capture by one clock to give the master data setup
         ssyn_out_h <= (state == S_SSYN) && (state_nx == S_SSYN);

         if (state == S_RDCAP && state_nx == S_SSYN)
            d_out_h <= mem_rdata;
         else if (state_nx != S_SSYN)
            d_out_h <= '0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_unibus_ram_slave.sv
`default_nettype none
// Directed self-checking bench for unibus_ram_slave with a block-RAM model.
module tb_unibus_ram_slave;

   localparam int DSK = 15;

   logic        CLOCK = 1'b0;
   logic        RESET_N = 1'b0;
   logic [17:0] a_in_h = '0;
   logic [1:0]  c_in_h = '0;
   logic [15:0] d_in_h = '0;
   logic        msyn_in_h = 1'b0;
   logic        init_in_h = 1'b0;
   logic [15:0] d_out_h;
   logic        ssyn_out_h;
   logic [14:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = '0;
   logic        mem_enab;
   logic [1:0]  mem_wena;
   logic        busy_h;

   int checks = 0;
   int failures = 0;
   int enab_cnt = 0;
   logic [1:0]  last_wena = '0;
   logic [14:0] last_addr = '0;
   logic [15:0] ram [0:32767];
   logic        ram_clr = 1'b0;

   unibus_ram_slave #(.BASE(18'o000000), .SIZE(28672), .AW(15), .DESKEW(DSK)) dut (
      .CLOCK(CLOCK), .RESET_N(RESET_N),
      .a_in_h(a_in_h), .c_in_h(c_in_h), .d_in_h(d_in_h),
      .msyn_in_h(msyn_in_h), .init_in_h(init_in_h),
      .d_out_h(d_out_h), .ssyn_out_h(ssyn_out_h),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_enab(mem_enab), .mem_wena(mem_wena), .busy_h(busy_h)
   );

   always #5 CLOCK = ~CLOCK;

   always @(posedge CLOCK) begin
      if (!ram_clr) begin
         for (int i = 0; i < 32768; i++) ram[i] <= '0;
         ram_clr <= 1'b1;
      end else if (mem_enab) begin
         enab_cnt  <= enab_cnt + 1;
         last_wena <= mem_wena;
         last_addr <= mem_addr;
         if (mem_wena[0]) ram[mem_addr][7:0]  <= mem_wdata[7:0];
         if (mem_wena[1]) ram[mem_addr][15:8] <= mem_wdata[15:8];
         mem_rdata <= ram[mem_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
      end
   endtask

   task automatic clk1();
      @(posedge CLOCK);
      @(negedge CLOCK);
   endtask

   task automatic bus_cycle(input logic [17:0] a, input logic [1:0] c, input logic [15:0] d,
                            output int lat, output logic [15:0] rd);
      lat = -1;
      rd  = '0;
      @(negedge CLOCK);
      a_in_h = a; c_in_h = c; d_in_h = d; msyn_in_h = 1'b1;
      for (int n = 1; n <= DSK + 20; n++) begin
         clk1();
         if (ssyn_out_h) begin
            lat = n - 1;
            rd  = d_out_h;
            break;
         end
      end
      msyn_in_h = 1'b0;
      clk1();
   endtask

   task automatic do_write(input string tag, input logic [17:0] a, input logic [1:0] c,
                           input logic [15:0] d, input logic [1:0] ew, input logic [14:0] ea);
      int lat, e0;
      logic [15:0] rd;
      e0 = enab_cnt;
      bus_cycle(a, c, d, lat, rd);
      chk({tag, "_lat"}, lat, DSK + 2);
      chk({tag, "_enab"}, enab_cnt - e0, 1);
      chk({tag, "_wena"}, last_wena, ew);
      chk({tag, "_addr"}, last_addr, ea);
      chk({tag, "_ssyn_drop"}, ssyn_out_h, 0);
   endtask

   task automatic do_read(input string tag, input logic [17:0] a, input logic [1:0] c,
                          input logic [15:0] ed);
      int lat, e0;
      logic [15:0] rd;
      e0 = enab_cnt;
      bus_cycle(a, c, 16'h0, lat, rd);
      chk({tag, "_lat"}, lat, DSK + 3);
      chk({tag, "_data"}, rd, ed);
      chk({tag, "_enab"}, enab_cnt - e0, 1);
      chk({tag, "_wena"}, last_wena, 2'b00);
      chk({tag, "_ssyn_drop"}, ssyn_out_h, 0);
      chk({tag, "_dout_drop"}, d_out_h, 0);
      chk({tag, "_idle"}, busy_h, 0);
   endtask

   initial begin
      int e0;
      int got;
      repeat (3) @(negedge CLOCK);
      chk("rst_dout", d_out_h, 0);
      chk("rst_ssyn", ssyn_out_h, 0);
      chk("rst_enab", mem_enab, 0);
      chk("rst_wena", mem_wena, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_busy", busy_h, 0);
      RESET_N = 1'b1;
      clk1();

      do_write("dato_100", 18'o000100, 2'b10, 16'o123456, 2'b11, 15'o40);
      do_read("dati_100", 18'o000100, 2'b00, 16'o123456);
      do_read("datip_100", 18'o000100, 2'b01, 16'o123456);

      do_write("datob_201", 18'o000201, 2'b11, 16'o177400, 2'b10, 15'o100);
      do_write("datob_200", 18'o000200, 2'b11, 16'o000252, 2'b01, 15'o100);
      do_read("dati_200", 18'o000200, 2'b00, 16'o177652);

      do_write("dato_top", 18'o157776, 2'b10, 16'o052525, 2'b11, 15'o67777);
      do_read("dati_top", 18'o157776, 2'b00, 16'o052525);

      // first address past the window
      e0 = enab_cnt;
      @(negedge CLOCK);
      a_in_h = 18'o160000; c_in_h = 2'b00; msyn_in_h = 1'b1;
      repeat (DSK + 10) clk1();
      chk("miss_ssyn", ssyn_out_h, 0);
      chk("miss_enab", enab_cnt - e0, 0);
      chk("miss_waitlo", busy_h, 1);
      msyn_in_h = 1'b0;
      clk1();
      chk("miss_idle", busy_h, 0);
      do_read("after_miss", 18'o000100, 2'b00, 16'o123456);

      // master abort during deskew
      e0 = enab_cnt;
      a_in_h = 18'o000100; c_in_h = 2'b10; d_in_h = 16'o777; msyn_in_h = 1'b1;
      repeat (5) clk1();
      chk("abort_busy", busy_h, 1);
      msyn_in_h = 1'b0;
      clk1();
      chk("abort_idle", busy_h, 0);
      repeat (DSK + 5) clk1();
      chk("abort_enab", enab_cnt - e0, 0);
      do_read("after_abort", 18'o000100, 2'b00, 16'o123456);

      // INIT while SSYN asserted on a read
      e0 = enab_cnt;
      got = 0;
      a_in_h = 18'o000100; c_in_h = 2'b00; msyn_in_h = 1'b1;
      for (int n = 0; n < DSK + 20; n++) begin
         clk1();
         if (ssyn_out_h) begin
            got = 1;
            break;
         end
      end
      chk("init_ssyn_seen", got, 1);
      chk("init_pre_data", d_out_h, 16'o123456);
      init_in_h = 1'b1;
      clk1();
      chk("init_ssyn", ssyn_out_h, 0);
      chk("init_dout", d_out_h, 0);
      chk("init_waitlo", busy_h, 1);
      init_in_h = 1'b0;
      repeat (DSK + 5) clk1();
      chk("init_hold_ssyn", ssyn_out_h, 0);
      chk("init_hold_enab", enab_cnt - e0, 1);
      msyn_in_h = 1'b0;
      clk1();
      chk("init_idle", busy_h, 0);
      do_read("after_init", 18'o000100, 2'b00, 16'o123456);

      // asynchronous reset mid-deskew
      a_in_h = 18'o000100; c_in_h = 2'b00; msyn_in_h = 1'b1;
      repeat (4) clk1();
      chk("areset_pre_busy", busy_h, 1);
      #1 RESET_N = 1'b0;
      #1;
      chk("areset_busy", busy_h, 0);
      chk("areset_ssyn", ssyn_out_h, 0);
      chk("areset_enab", mem_enab, 0);
      chk("areset_addr", mem_addr, 0);
      chk("areset_wdata", mem_wdata, 0);
      chk("areset_dout", d_out_h, 0);
      msyn_in_h = 1'b0;
      @(negedge CLOCK);
      RESET_N = 1'b1;
      clk1();
      do_read("after_reset", 18'o000100, 2'b00, 16'o123456);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
